// File: rtl/swap_sort_pkg.sv
// Shared types and sizing helpers for the swap-based sorting engine.
// Default parameters live here so the controller and benches agree on them.
package swap_sort_pkg;

  typedef enum logic [1:0] {
    LOAD,
    SORT,
    DRAIN
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  // Index width for a frame of the given depth; never narrower than one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/data_swapper.sv
// Combinational two-word exchanger: passes the pair straight through,
// or crossed over when swap_en is high.
module data_swapper #(
  parameter int N = 8
) (
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic         swap_en,
  output logic [N-1:0] out1,
  output logic [N-1:0] out2
);

  assign out1 = swap_en ? in2 : in1;
  assign out2 = swap_en ? in1 : in2;

endmodule

// File: rtl/swap_sort_ctrl.sv
// Frame sorter: loads DEPTH words, bubble-sorts them in place one adjacent
// pair per cycle through a single data_swapper, then streams them out.
module swap_sort_ctrl
  import swap_sort_pkg::*;
#(
  parameter int N      = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ASCEND = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         busy,
  output logic         done
);

  localparam int IDX_W = idx_width(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] PAIR_IDX = IDX_W'(DEPTH - 2);

  state_t           state, next_state;
  logic [N-1:0]     mem [DEPTH];
  logic [IDX_W-1:0] wr_idx, rd_idx, cmp_idx, cmp_nxt, pass_cnt;
  logic             swapped;

  logic [N-1:0]     swap_in1, swap_in2, swap_out1, swap_out2;
  logic             swap_en;
  logic             in_fire, out_fire, pass_end, sort_exit;

  assign cmp_nxt  = cmp_idx + IDX_W'(1);
  assign swap_in1 = mem[cmp_idx];
  assign swap_in2 = mem[cmp_nxt];

  // Strict unsigned compare, so equal words stay put and the sort is stable.
  assign swap_en  = (state == SORT) &&
                    ((ASCEND != 0) ? (swap_in1 > swap_in2) : (swap_in1 < swap_in2));

  data_swapper #(.N(N)) u_swapper (
    .in1     (swap_in1),
    .in2     (swap_in2),
    .swap_en (swap_en),
    .out1    (swap_out1),
    .out2    (swap_out2)
  );

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign pass_end  = (cmp_idx == PAIR_IDX);
  // A clean pass, or the pass cap, ends the sort; this cycle's swap counts.
  assign sort_exit = pass_end && (!(swapped || swap_en) || (pass_cnt == PAIR_IDX));
  assign out_data  = (state == DRAIN) ? mem[rd_idx] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (wr_idx == LAST_IDX)) next_state = SORT;
      end
      SORT: begin
        busy = 1'b1;
        if (sort_exit) next_state = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready && (rd_idx == LAST_IDX)) next_state = LOAD;
      end
      default: next_state = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_idx   <= '0;
      rd_idx   <= '0;
      cmp_idx  <= '0;
      pass_cnt <= '0;
      swapped  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= out_fire && (rd_idx == LAST_IDX);
      case (state)
        LOAD: begin
          if (in_fire) begin
            mem[wr_idx] <= in_data;
            if (wr_idx == LAST_IDX) begin
              wr_idx   <= '0;
              cmp_idx  <= '0;
              pass_cnt <= '0;
              swapped  <= 1'b0;
            end else begin
              wr_idx <= wr_idx + IDX_W'(1);
            end
          end
        end
        SORT: begin
          mem[cmp_idx] <= swap_out1;
          mem[cmp_nxt] <= swap_out2;
          if (pass_end && !sort_exit) begin
            pass_cnt <= pass_cnt + IDX_W'(1);
            cmp_idx  <= '0;
            swapped  <= 1'b0;
          end else begin
            swapped <= swapped || swap_en;
            if (!pass_end) cmp_idx <= cmp_nxt;
          end
        end
        DRAIN: begin
          if (out_fire) begin
            rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_swap_sort_ctrl.sv
// Directed bench for swap_sort_ctrl: one ascending and one descending
// instance, driven one at a time through shared stimulus signals.
module tb_swap_sort_ctrl;

  typedef logic [7:0] frame_t [8];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       use_desc = 1'b0;

  always #5 clk = ~clk;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy, a_done;
  logic [7:0] a_out_data;
  logic       d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_busy, d_done;
  logic [7:0] d_out_data;

  assign a_in_valid  = in_valid  && !use_desc;
  assign a_out_ready = out_ready && !use_desc;
  assign d_in_valid  = in_valid  && use_desc;
  assign d_out_ready = out_ready && use_desc;

  logic       cur_in_ready, cur_out_valid, cur_busy, cur_done;
  logic [7:0] cur_out_data;

  assign cur_in_ready  = use_desc ? d_in_ready  : a_in_ready;
  assign cur_out_valid = use_desc ? d_out_valid : a_out_valid;
  assign cur_busy      = use_desc ? d_busy      : a_busy;
  assign cur_done      = use_desc ? d_done      : a_done;
  assign cur_out_data  = use_desc ? d_out_data  : a_out_data;

  swap_sort_ctrl #(.N(8), .DEPTH(8), .ASCEND(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .busy      (a_busy),
    .done      (a_done)
  );

  swap_sort_ctrl #(.N(8), .DEPTH(8), .ASCEND(0)) dut_desc (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (d_in_valid),
    .in_ready  (d_in_ready),
    .in_data   (in_data),
    .out_valid (d_out_valid),
    .out_ready (d_out_ready),
    .out_data  (d_out_data),
    .busy      (d_busy),
    .done      (d_done)
  );

  int checks = 0;
  int errors = 0;

  frame_t f_inc     = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
  frame_t f_dec     = '{8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
  frame_t f_mix     = '{8'h55, 8'hAA, 8'h55, 8'h00, 8'hFF, 8'hAA, 8'h00, 8'hFF};
  frame_t e_mix_asc = '{8'h00, 8'h00, 8'h55, 8'h55, 8'hAA, 8'hAA, 8'hFF, 8'hFF};
  frame_t e_mix_dsc = '{8'hFF, 8'hFF, 8'hAA, 8'hAA, 8'h55, 8'h55, 8'h00, 8'h00};

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Insertion sort, ascending, as the independent reference.
  function automatic frame_t sort_frame(input frame_t f);
    frame_t     r;
    logic [7:0] t;
    r = f;
    for (int i = 1; i < 8; i++)
      for (int j = i; j > 0; j--)
        if (r[j-1] > r[j]) begin
          t = r[j]; r[j] = r[j-1]; r[j-1] = t;
        end
    return r;
  endfunction

  // Entered at a falling edge; returns 1 time unit after the final accept.
  task automatic load_words(input frame_t f, input bit gaps);
    int i = 0;
    int guard = 0;
    bit v;
    while (1) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_valid = v;
      in_data  = f[i];
      if (v && cur_in_ready) i++;
      if (i == 8 || guard > 500) break;
      @(negedge clk);
      guard++;
    end
    check_output("load_accepts", i, 8);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sort(input bit hold, input int exp_lat);
    int lat = 0;
    in_valid = hold;
    in_data  = 8'hEE;
    @(negedge clk);
    check_output("sort_busy", cur_busy, 1'b1);
    check_output("sort_in_ready", cur_in_ready, 1'b0);
    while (!cur_out_valid && lat < 400) begin
      lat++;
      @(negedge clk);
    end
    if (exp_lat >= 0) check_output("sort_latency", lat, exp_lat);
    else              check_output("sort_finished", lat < 400, 1'b1);
  endtask

  // Entered at the first falling edge with out_valid high; ends in the done cycle.
  task automatic drain_words(input frame_t e, input bit gaps);
    int         j = 0;
    int         guard = 0;
    int         dones = 0;
    bit         r;
    bit         held = 1'b0;
    logic [7:0] held_data = 8'h00;
    while (1) begin
      r = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      out_ready = r;
      if (held) begin
        check_output("hold_data", cur_out_data, held_data);
        check_output("hold_valid", cur_out_valid, 1'b1);
      end
      if (cur_done) dones++;
      if (cur_out_valid && r) begin
        check_output($sformatf("out_word%0d", j), cur_out_data, e[j]);
        j++;
        held = 1'b0;
      end else if (cur_out_valid) begin
        held      = 1'b1;
        held_data = cur_out_data;
      end
      if (j == 8 || guard > 500) break;
      @(negedge clk);
      guard++;
    end
    check_output("drain_words", j, 8);
    check_output("done_early", dones, 0);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_output("done_pulse", cur_done, 1'b1);
    check_output("done_in_ready", cur_in_ready, 1'b1);
  endtask

  task automatic apply_stimulus(input frame_t f, input frame_t e, input bit gaps,
                                input bit hold, input int exp_lat);
    load_words(f, gaps);
    wait_sort(hold, exp_lat);
    drain_words(e, gaps);
  endtask

  initial begin
    frame_t rf;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_in_ready", a_in_ready, 1'b1);
    check_output("rst_out_valid", a_out_valid, 1'b0);
    check_output("rst_busy", a_busy, 1'b0);
    check_output("rst_done", a_done, 1'b0);
    check_output("rst_out_data", a_out_data, 8'h00);
    check_output("rst_desc_in_ready", d_in_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("idle_busy", a_busy, 1'b0);

    // Ordered frame, then reversed frame back-to-back with in_valid held high.
    apply_stimulus(f_inc, f_inc, 1'b0, 1'b0, 7);
    apply_stimulus(f_dec, f_inc, 1'b0, 1'b1, 49);
    @(negedge clk);
    check_output("done_single", a_done, 1'b0);

    apply_stimulus(f_mix, e_mix_asc, 1'b0, 1'b0, -1);

    // Reset in the middle of a sort discards the frame.
    load_words(f_dec, 1'b0);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("midsort_in_ready", a_in_ready, 1'b1);
    check_output("midsort_busy", a_busy, 1'b0);
    check_output("midsort_out_valid", a_out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apply_stimulus(f_mix, e_mix_asc, 1'b0, 1'b0, -1);

    use_desc = 1'b1;
    apply_stimulus(f_mix, e_mix_dsc, 1'b0, 1'b0, -1);
    use_desc = 1'b0;

    for (int k = 0; k < 100; k++) begin
      for (int i = 0; i < 8; i++)
        rf[i] = (k % 3 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      apply_stimulus(rf, sort_frame(rf), 1'b1, k[0], -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
